// File: rtl/test_stop_sequencer_pkg.sv
// Shared test-harness definitions: sequencer state encoding and default sizing.
package test_stop_sequencer_pkg;

   localparam int unsigned DefaultNumStages     = 4;
   localparam int unsigned DefaultTimeoutCycles = 1024;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StRun     = 3'd1,
      StAdvance = 3'd2,
      StDone    = 3'd3,
      StHalt    = 3'd4
   } seq_state_e;

   // Width of a counter able to hold 0..limit-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle timer: counts enabled cycles since the last clear and flags the final
// allowed cycle of a stage.
module stage_watchdog
   import test_stop_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] count_q, count_d;

   // Next count: clear wins; hold at the limit so the counter can never wrap.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != Limit)) begin
         count_d = count_q + CntW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable && (count_q == Limit);

endmodule

// File: rtl/test_stop_sequencer.sv
// Test stop sequencer: walks the test stages one at a time, records a sticky verdict and
// emits a one-cycle finish pulse that stops the harness.
module test_stop_sequencer
   import test_stop_sequencer_pkg::*;
#(
   parameter int unsigned NUM_STAGES     = DefaultNumStages,
   parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [NUM_STAGES-1:0]         stage_done,
   input  logic [NUM_STAGES-1:0]         stage_fail,
   output logic [NUM_STAGES-1:0]         stage_go,
   output logic                          busy,
   output logic                          finish,
   output logic                          passed,
   output logic                          failed,
   output logic [$clog2(NUM_STAGES)-1:0] fail_stage,
   output logic                          timed_out,
   output logic [31:0]                   total_cycles
);

   localparam int unsigned IdxW = $clog2(NUM_STAGES);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_STAGES - 1);

   seq_state_e      state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [31:0]     total_q, total_d;
   logic            passed_q, passed_d;
   logic            failed_q, failed_d;
   logic [IdxW-1:0] fail_stage_q, fail_stage_d;
   logic            timed_out_q, timed_out_d;

   logic timer_clear, timer_enable, timer_expired;
   logic stage_hit, stage_bad;

   // Only the active stage's strobes matter; all other bits are don't-care.
   assign stage_hit = stage_done[idx_q];
   assign stage_bad = stage_fail[idx_q];

   stage_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // Next-state, verdict updates and decoded outputs.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      total_d      = total_q;
      passed_d     = passed_q;
      failed_d     = failed_q;
      fail_stage_d = fail_stage_q;
      timed_out_d  = timed_out_q;
      stage_go     = '0;
      busy         = 1'b0;
      finish       = 1'b0;
      timer_clear  = 1'b1;
      timer_enable = 1'b0;

      unique case (state_q)
         StIdle, StHalt: begin
            if (start) begin
               state_d      = StRun;
               idx_d        = '0;
               total_d      = '0;
               passed_d     = 1'b0;
               failed_d     = 1'b0;
               fail_stage_d = '0;
               timed_out_d  = 1'b0;
            end
         end

         StRun: begin
            stage_go     = NUM_STAGES'(1) << idx_q;
            busy         = 1'b1;
            timer_clear  = 1'b0;
            timer_enable = 1'b1;
            total_d      = (total_q == '1) ? total_q : total_q + 32'd1;
            // A done strobe beats a timeout landing on the same cycle.
            if (stage_hit) begin
               if (stage_bad) begin
                  state_d      = StDone;
                  failed_d     = 1'b1;
                  fail_stage_d = idx_q;
               end else if (idx_q == LastIdx) begin
                  state_d  = StDone;
                  passed_d = 1'b1;
               end else begin
                  state_d = StAdvance;
               end
            end else if (timer_expired) begin
               state_d      = StDone;
               failed_d     = 1'b1;
               timed_out_d  = 1'b1;
               fail_stage_d = idx_q;
            end
         end

         StAdvance: begin
            busy    = 1'b1;
            total_d = (total_q == '1) ? total_q : total_q + 32'd1;
            idx_d   = idx_q + IdxW'(1);
            state_d = StRun;
         end

         StDone: begin
            finish  = 1'b1;
            state_d = StHalt;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and verdict registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         total_q      <= '0;
         passed_q     <= 1'b0;
         failed_q     <= 1'b0;
         fail_stage_q <= '0;
         timed_out_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         total_q      <= total_d;
         passed_q     <= passed_d;
         failed_q     <= failed_d;
         fail_stage_q <= fail_stage_d;
         timed_out_q  <= timed_out_d;
      end
   end

   assign passed       = passed_q;
   assign failed       = failed_q;
   assign fail_stage   = fail_stage_q;
   assign timed_out    = timed_out_q;
   assign total_cycles = total_q;

endmodule

// File: tb/tb_test_stop_sequencer.sv
// Scoreboard bench for test_stop_sequencer: the driver pushes the model's verdict for each
// sequence, the monitor pops and compares it when finish pulses.
module tb_test_stop_sequencer;

   localparam int NS        = 4;
   localparam int TO        = 16;
   localparam int NEVER     = 1000;
   localparam int MaxCycles = 400;

   typedef struct {
      logic        passed;
      logic        failed;
      int          fail_stage;
      logic        timed_out;
      int unsigned total;
      int unsigned latency;
      logic [NS-1:0] go_mask;
      int unsigned start_cyc;
   } exp_t;

   logic          clock;
   logic          reset;
   logic          start;
   logic [NS-1:0] stage_done;
   logic [NS-1:0] stage_fail;
   logic [NS-1:0] stage_go;
   logic          busy;
   logic          finish;
   logic          passed;
   logic          failed;
   logic [1:0]    fail_stage;
   logic          timed_out;
   logic [31:0]   total_cycles;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;
   exp_t        exp_q[$];
   int          dl[NS];
   bit          fl[NS];

   test_stop_sequencer #(
      .NUM_STAGES     (NS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .stage_done   (stage_done),
      .stage_fail   (stage_fail),
      .stage_go     (stage_go),
      .busy         (busy),
      .finish       (finish),
      .passed       (passed),
      .failed       (failed),
      .fail_stage   (fail_stage),
      .timed_out    (timed_out),
      .total_cycles (total_cycles)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Reference model: outcome of a sequence from per-stage done delays and fail flags.
   function automatic exp_t model(input int d[NS], input bit f[NS]);
      exp_t e;
      e.passed = 0; e.failed = 0; e.fail_stage = 0; e.timed_out = 0;
      e.total = 0; e.go_mask = '0; e.start_cyc = 0;
      for (int s = 0; s < NS; s++) begin
         e.go_mask[s] = 1'b1;
         if (d[s] >= TO) begin
            e.total += TO; e.failed = 1; e.timed_out = 1; e.fail_stage = s;
            break;
         end
         e.total += d[s] + 1;
         if (f[s]) begin
            e.failed = 1; e.fail_stage = s;
            break;
         end
         if (s == NS - 1) e.passed = 1;
         else e.total += 1;
      end
      e.latency = e.total + 1;
      return e;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_go"}, stage_go, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_finish"}, finish, 0);
      check({tag, "_passed"}, passed, 0);
      check({tag, "_failed"}, failed, 0);
      check({tag, "_fail_stage"}, fail_stage, 0);
      check({tag, "_timed_out"}, timed_out, 0);
      check({tag, "_total"}, total_cycles, 0);
   endtask

   // Runs one sequence from IDLE/HALT, answering each stage as it is enabled.
   task automatic run_seq(input int d[NS], input bit f[NS]);
      exp_t e;
      int cur, cnt, i;
      bit ended;
      logic [NS-1:0] sd, sf;
      e = model(d, f);
      start = 1'b1;
      e.start_cyc = cyc;
      exp_q.push_back(e);
      @(negedge clock);
      start = 1'b0;
      check("go_after_start", stage_go, 1);
      check("clear_passed", passed, 0);
      check("clear_failed", failed, 0);
      check("clear_timed_out", timed_out, 0);
      check("clear_total", total_cycles, 0);
      cur = -1; cnt = 0; ended = 0;
      for (int c = 0; c < MaxCycles; c++) begin
         if (!busy && !finish) begin
            ended = 1;
            break;
         end
         sd = NS'($urandom);
         sf = NS'($urandom);
         if (stage_go != '0) begin
            i = 0;
            for (int k = 0; k < NS; k++) if (stage_go[k]) i = k;
            if (i != cur) begin
               cur = i; cnt = 0;
            end else begin
               cnt++;
            end
            sd[i] = (cnt == d[i]);
            if (sd[i]) sf[i] = f[i];
         end
         stage_done = sd;
         stage_fail = sf;
         start = 1'($urandom_range(0, 1));
         @(negedge clock);
      end
      stage_done = '0;
      stage_fail = '0;
      start = 1'b0;
      if (!ended) begin
         n_checks++;
         $display("FAIL seq_bound: sequence still running after %0d cycles, expected HALT",
                  MaxCycles);
      end else begin
         check("halt_go", stage_go, 0);
         check("halt_passed", passed, e.passed);
         check("halt_failed", failed, e.failed);
         check("halt_fail_stage", fail_stage, e.fail_stage);
         check("halt_timed_out", timed_out, e.timed_out);
         check("halt_total", total_cycles, e.total);
      end
   endtask

   // Monitor: compares each finish pulse against the oldest expected outcome.
   initial begin
      logic [NS-1:0] go_acc;
      logic finish_prev;
      exp_t e;
      go_acc = '0;
      finish_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            go_acc = '0;
            finish_prev = 1'b0;
         end else begin
            go_acc |= stage_go;
            if (finish) begin
               check("finish_single", finish_prev, 0);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_finish: finish=1 with no sequence pending");
               end else begin
                  e = exp_q.pop_front();
                  check("fin_passed", passed, e.passed);
                  check("fin_failed", failed, e.failed);
                  check("fin_fail_stage", fail_stage, e.fail_stage);
                  check("fin_timed_out", timed_out, e.timed_out);
                  check("fin_total", total_cycles, e.total);
                  check("fin_latency", cyc - e.start_cyc, e.latency);
                  check("fin_go_mask", go_acc, e.go_mask);
               end
               go_acc = '0;
            end
            finish_prev = finish;
         end
      end
   end

   initial begin
      bit seen;
      reset = 1'b1;
      start = 1'b0;
      stage_done = '0;
      stage_fail = '0;
      repeat (2) @(negedge clock);
      check_zero("in_reset");
      reset = 1'b0;
      @(negedge clock);
      check_zero("idle");

      // All stages pass, done three cycles after each go.
      dl = '{3, 3, 3, 3}; fl = '{0, 0, 0, 0};
      run_seq(dl, fl);
      // Stage 2 reports a failure.
      dl = '{3, 3, 3, 3}; fl = '{0, 0, 1, 0};
      run_seq(dl, fl);
      // Restart from HALT after a fail.
      dl = '{0, 1, 2, 0}; fl = '{0, 0, 0, 0};
      run_seq(dl, fl);
      // Stage 1 never completes.
      dl = '{3, NEVER, 3, 3}; fl = '{0, 0, 0, 0};
      run_seq(dl, fl);
      // Done lands on the timeout cycle.
      dl = '{2, TO - 1, 2, 2}; fl = '{0, 0, 0, 0};
      run_seq(dl, fl);

      // Reset during stage 1: everything clears at once and no finish follows.
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      stage_done = 4'b0001;
      @(negedge clock);
      stage_done = '0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (stage_go == 4'b0010) begin
            seen = 1;
            break;
         end
         @(negedge clock);
      end
      check("reach_stage1", seen, 1);
      @(negedge clock);
      #2 reset = 1'b1;
      #1 check_zero("async_reset");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check_zero("after_reset");
      dl = '{1, 2, 3, 4}; fl = '{0, 0, 0, 0};
      run_seq(dl, fl);

      // Randomized sequences.
      for (int r = 0; r < 40; r++) begin
         for (int s = 0; s < NS; s++) begin
            int unsigned p;
            p = $urandom_range(0, 9);
            dl[s] = (p == 0) ? NEVER : (p == 1) ? TO - 1 : int'($urandom_range(0, 6));
            fl[s] = ($urandom_range(0, 7) == 0);
         end
         run_seq(dl, fl);
      end

      repeat (3) @(negedge clock);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
